// File: rtl/alu_seq_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_seq_pkg;

  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_ADD = 2'b00;
  localparam opcode_t OP_SUB = 2'b01;
  localparam opcode_t OP_MUL = 2'b10;
  localparam opcode_t OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one bit per cycle.
// hi/lo present the accumulator value *after* the current iteration, so the
// parent can capture the final result on the same edge the last step retires.
module alu_iter_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opb;
  logic             div_q;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  // One shift-add or restore-subtract step on the shared accumulator
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    ge      = (shifted >= {1'b0, opb});
    div_hi  = ge ? WIDTH'(shifted - {1'b0, opb}) : shifted[WIDTH-1:0];
    div_lo  = {acc_lo[WIDTH-2:0], ge};
    hi      = div_q ? div_hi : mul_hi;
    lo      = div_q ? div_lo : mul_lo;
  end

  assign busy = (cnt != '0);
  assign done = (cnt == CNT_W'(1));

  // Accumulator load on start, then one iteration per cycle while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      div_q  <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      acc_hi <= '0;
      acc_lo <= a;
      opb    <= b;
      div_q  <= is_div;
      cnt    <= CNT_W'(WIDTH);
    end else if (busy) begin
      acc_hi <= hi;
      acc_lo <= lo;
      cnt    <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ADD/SUB, iterative MUL/DIV, valid/ready handshakes.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       opcode_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_out_low,
  output logic [WIDTH-1:0] result_out_hi,
  output logic             carry,
  output logic             borrow,
  output logic             zero,
  output logic             error_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           state_q;
  state_t           state_d;
  logic             load;
  logic             start;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH-1:0] hi_d;
  logic             carry_d;
  logic             borrow_d;
  logic             err_d;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic             it_busy;
  logic             it_done;
  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_lo;

  alu_iter_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .is_div (opcode_in == OP_DIV),
    .a      (A_in),
    .b      (B_in),
    .busy   (it_busy),
    .done   (it_done),
    .hi     (it_hi),
    .lo     (it_lo)
  );

  assign sum_w     = {1'b0, A_in} + {1'b0, B_in};
  assign diff_w    = {1'b0, A_in} - {1'b0, B_in};
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);

  // Next-state and result selection; result registers load only on entry to DONE
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    start    = 1'b0;
    lo_d     = '0;
    hi_d     = '0;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          case (opcode_in)
            OP_ADD: begin
              load    = 1'b1;
              lo_d    = sum_w[WIDTH-1:0];
              carry_d = sum_w[WIDTH];
              state_d = DONE;
            end
            OP_SUB: begin
              load     = 1'b1;
              lo_d     = diff_w[WIDTH-1:0];
              borrow_d = diff_w[WIDTH];
              state_d  = DONE;
            end
            OP_MUL: begin
              start   = 1'b1;
              state_d = BUSY;
            end
            OP_DIV: begin
              if (B_in == '0) begin
                load    = 1'b1;
                err_d   = 1'b1;
                lo_d    = '1;
                hi_d    = A_in;
                state_d = DONE;
              end else begin
                start   = 1'b1;
                state_d = BUSY;
              end
            end
          endcase
        end
      end
      BUSY: begin
        if (it_done && it_busy) begin
          load    = 1'b1;
          lo_d    = it_lo;
          hi_d    = it_hi;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      result_out_low <= '0;
      result_out_hi  <= '0;
      carry          <= 1'b0;
      borrow         <= 1'b0;
      zero           <= 1'b0;
      error_out      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        result_out_low <= lo_d;
        result_out_hi  <= hi_d;
        carry          <= carry_d;
        borrow         <= borrow_d;
        zero           <= (lo_d == '0);
        error_out      <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        vld32;
  logic        vld8;
  logic        ordy;
  logic        sel8;

  logic        rdy32, ov32, c32, bw32, z32, e32;
  logic [31:0] lo32, hi32;
  logic        rdy8, ov8, c8, bw8, z8, e8;
  logic [7:0]  lo8, hi8;

  logic        o_rdy, o_ov, o_c, o_bw, o_z, o_e;
  logic [31:0] o_lo, o_hi;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(vld32), .in_ready(rdy32), .opcode_in(op),
    .A_in(a), .B_in(b), .out_valid(ov32), .out_ready(ordy),
    .result_out_low(lo32), .result_out_hi(hi32), .carry(c32), .borrow(bw32),
    .zero(z32), .error_out(e32)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(vld8), .in_ready(rdy8), .opcode_in(op),
    .A_in(a[7:0]), .B_in(b[7:0]), .out_valid(ov8), .out_ready(ordy),
    .result_out_low(lo8), .result_out_hi(hi8), .carry(c8), .borrow(bw8),
    .zero(z8), .error_out(e8)
  );

  // Observation mux onto whichever instance is under test
  always_comb begin
    o_rdy = sel8 ? rdy8 : rdy32;
    o_ov  = sel8 ? ov8  : ov32;
    o_lo  = sel8 ? {24'h0, lo8} : lo32;
    o_hi  = sel8 ? {24'h0, hi8} : hi32;
    o_c   = sel8 ? c8   : c32;
    o_bw  = sel8 ? bw8  : bw32;
    o_z   = sel8 ? z8   : z32;
    o_e   = sel8 ? e8   : e32;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: results straight from the operation definitions
  task automatic model(input int w, input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       output logic [63:0] lo, output logic [63:0] hi, output logic cy,
                       output logic bw, output logic z, output logic er, output int lat);
    logic [63:0] mask, aa, bb, t;
    mask = (64'd1 << w) - 64'd1;
    aa = {32'h0, av} & mask;
    bb = {32'h0, bv} & mask;
    lo = 64'h0; hi = 64'h0; cy = 1'b0; bw = 1'b0; er = 1'b0; lat = 1;
    case (o)
      2'b00: begin t = aa + bb; lo = t & mask; cy = t[w]; end
      2'b01: begin lo = (aa - bb) & mask; bw = (aa < bb); end
      2'b10: begin t = aa * bb; lo = t & mask; hi = (t >> w) & mask; lat = w + 1; end
      default: begin
        if (bb == 64'h0) begin er = 1'b1; lo = mask; hi = aa; end
        else begin lo = aa / bb; hi = aa % bb; lat = w + 1; end
      end
    endcase
    z = (lo == 64'h0);
  endtask

  task automatic run(input string tag, input int w, input logic [1:0] o,
                     input logic [31:0] av, input logic [31:0] bv, input int hold);
    logic [63:0] e_lo, e_hi;
    logic e_c, e_bw, e_z, e_e, busy_ok, hold_ok;
    int e_lat, lat;
    model(w, o, av, bv, e_lo, e_hi, e_c, e_bw, e_z, e_e, e_lat);
    sel8 = (w == 8);
    #0;
    chk({tag, ".ready_idle"}, o_rdy, 1);
    op = o; a = av; b = bv;
    if (w == 8) vld8 = 1'b1; else vld32 = 1'b1;
    @(posedge clk); #1;
    vld8 = 1'b0; vld32 = 1'b0;
    lat = 1; busy_ok = 1'b1;
    while (!o_ov && lat < 200) begin
      if (o_rdy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, e_lat);
    chk({tag, ".ready_busy"}, busy_ok, 1);
    chk({tag, ".lo"}, o_lo, e_lo);
    chk({tag, ".hi"}, o_hi, e_hi);
    chk({tag, ".carry"}, o_c, e_c);
    chk({tag, ".borrow"}, o_bw, e_bw);
    chk({tag, ".zero"}, o_z, e_z);
    chk({tag, ".error"}, o_e, e_e);
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!o_ov || o_rdy || o_lo !== e_lo[31:0] || o_hi !== e_hi[31:0] ||
          o_c !== e_c || o_bw !== e_bw || o_z !== e_z || o_e !== e_e) hold_ok = 1'b0;
    end
    if (hold > 0) chk({tag, ".hold"}, hold_ok, 1);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk({tag, ".valid_drop"}, o_ov, 0);
    chk({tag, ".ready_back"}, o_rdy, 1);
  endtask

  initial begin
    logic quiet;
    rst = 1'b1; op = 2'b00; a = '0; b = '0; vld32 = 1'b0; vld8 = 1'b0; ordy = 1'b0; sel8 = 1'b0;
    @(posedge clk); #1;
    chk("rst.ready", o_rdy, 0);
    @(posedge clk); #1;
    chk("rst.valid", o_ov, 0);
    chk("rst.lo", o_lo, 0);
    chk("rst.zero", o_z, 0);
    rst = 1'b0;
    #1;
    chk("rst.ready_after", o_rdy, 1);

    run("add_wrap", 32, 2'b00, 32'hFFFF_FFFF, 32'h1, 0);
    run("sub_neg",  32, 2'b01, 32'd5, 32'd7, 0);
    run("mul_max",  32, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run("div_100_7", 32, 2'b11, 32'd100, 32'd7, 0);
    run("div_zero", 32, 2'b11, 32'h1234, 32'h0, 5);
    run("mul_hold", 32, 2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 5);
    run("mul8_max", 8, 2'b10, 32'hFF, 32'hFF, 0);
    run("div8",     8, 2'b11, 32'hC8, 32'h07, 3);
    run("div8_zero", 8, 2'b11, 32'h5A, 32'h00, 0);

    // Reset in the middle of a DIV aborts it
    sel8 = 1'b0;
    op = 2'b11; a = 32'd1000; b = 32'd3; vld32 = 1'b1;
    @(posedge clk); #1;
    vld32 = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("abort.ready_in_rst", o_rdy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort.valid", o_ov, 0);
    chk("abort.lo", o_lo, 0);
    chk("abort.hi", o_hi, 0);
    chk("abort.error", o_e, 0);
    chk("abort.ready", o_rdy, 1);
    quiet = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (o_ov) quiet = 1'b0; end
    chk("abort.no_valid", quiet, 1);

    // Randomized operations on both widths
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_000F;
      run($sformatf("rnd%0d", i), (i % 2 == 1) ? 8 : 32, 2'($urandom_range(0, 3)),
          ra, rb, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
